clock_enable_generator: RTL and testbench
=========================================

# clock_enable_generator

Parametrised, multi-channel successor to the fixed ripple-counter divider chain. It produces per-channel single-cycle tick enables and 50%-duty square outputs, all synchronous to one system clock rather than ripple-derived clocks. Each channel's divisor can be changed at run time through a load handshake. Channels can be cascaded at elaboration time so that one counts the ticks of the channel below it. It sits between the board clock and every timing consumer (display scan, debounce, seconds counter).

## Interface
- CHANNELS, 4: number of divider channels, 1..16.
- WIDTH, 16: divisor/counter width in bits, ≥2.
- DIV_INIT, 50: reset divisor for every channel; must fit in WIDTH bits.
- CASCADE, {CHANNELS{1'b0}}: bit i=1 makes channel i count TICK[i-1] instead of clock cycles; bit 0 ignored.
- CH_W, derived: max(1, ceil(log2(CHANNELS))).

Ports:
- CP  in  1  system clock, rising edge.
- nCR  in  1  asynchronous active-low reset.
- EN  in  1  global count enable, synchronous.
- CLR  in  1  synchronous clear of all counters; divisors retained.
- LD  in  1  load strobe.
- LD_CH  in  CH_W  channel index for load.
- LD_DIV  in  WIDTH  new divisor.
- LD_ACK  out  1  one-cycle pulse: load accepted.
- LD_ERR  out  1  one-cycle pulse: LD_CH ≥ CHANNELS, load discarded.
- TICK  out  CHANNELS  one-cycle enable pulse per channel period.
- SQ  out  CHANNELS  square output per channel.

## Operation
- Per channel: divisor register DIV[i], counter CNT[i], registered TICK[i] and SQ[i].
- Count event: EN=1 and (CASCADE[i]=0 or i=0 ? every cycle : TICK[i-1]=1 in that cycle).
- On an event: if CNT==DIV-1 then CNT←0, TICK←1, SQ←~SQ; else CNT←CNT+1, TICK←0.
- No event: CNT and SQ hold, TICK←0. TICK is never high for two consecutive cycles unless DIV=1.
- DIV=0: channel disabled, CNT held at 0, TICK=0, SQ=0.
- DIV=1: TICK high on every event; SQ toggles on every event.
- Arithmetic is unsigned WIDTH-bit. CNT never exceeds DIV-1. Wrap-around to 0 occurs only at DIV-1.
- Load: when LD=1 and LD_CH<CHANNELS, at that edge DIV[LD_CH]←LD_DIV, CNT←0, TICK←0, SQ←0, and LD_ACK←1 for one cycle. Other channels are unaffected.
- Load with LD_CH≥CHANNELS (non-power-of-two builds only): no state change, LD_ERR←1 for one cycle.
- LD held for N cycles: the reload occurs every cycle, CNT stays 0, and LD_ACK stays high N cycles.
- Priority per edge: nCR > CLR > LD > count.
- CLR=1 sets all CNT←0, TICK←0, SQ←0. A simultaneous LD still writes DIV and acknowledges.
- LD on a channel in its wrap cycle: the load wins and no TICK is issued.
- A downstream cascaded channel sees no tick from a channel that is reloading or cleared.
- Reset (nCR=0, asynchronous): DIV[i]=DIV_INIT, CNT=0, TICK=0, SQ=0, LD_ACK=0, LD_ERR=0. Removal of reset mid-period restarts every channel from CNT=0.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- First TICK[i] of a non-cascaded channel appears after the DIV-th rising edge with EN=1 following reset, CLR, or load. The period after that is DIV cycles.
- SQ period is 2·DIV events, with exactly 50% duty.
- A cascaded channel's event is the upstream registered TICK. Its TICK therefore lags the upstream tick that completes its period by 1 cycle, and its period is DIV[i]·period(i-1).
- LD_ACK and LD_ERR are high in the cycle after the LD edge. The new divisor is active from that same cycle.
- Changes to EN take effect at the next edge. With EN=0, TICK is 0 from the cycle after EN falls.

## Test plan
- Reset release, CHANNELS=4, WIDTH=8, DIV_INIT=5, EN=1 -> TICK[0] first high after edge 5, then at edges 10, 15, …; SQ[0] high over edges 5..9 and low over 10..14; LD_ACK=LD_ERR=0.
- CASCADE=4'b0010, load DIV[1]=3 -> LD_ACK pulse. TICK[1] recurs every 15 cycles and is 1 cycle after every third TICK[0].
- LD with LD_CH=2, LD_DIV=1 at edge k -> LD_ACK high after edge k. TICK[2] high from edge k+1 onward every cycle, and SQ[2] toggles every cycle.
- LD with LD_CH=1, LD_DIV=0 -> TICK[1]=0 and SQ[1]=0 indefinitely. A later LD with LD_DIV=4 restores ticks every 4 events.
- CHANNELS=3 build, LD_CH=3 -> LD_ERR pulse, no LD_ACK, and all divisors unchanged.
- Sequence: EN low for 7 cycles mid-period -> CNT frozen, no TICK, and the period resumes with no lost or extra counts. Then CLR and LD pulse in the same cycle -> all CNT=0, the targeted DIV is updated, and LD_ACK pulses. Then nCR asserted mid-period -> all outputs 0 immediately and all DIV=5.

Source files
------------

// File: rtl/clock_enable_generator.sv
// clock_enable_generator: multi-channel synchronous divider producing per-channel tick enables
// and 50% square outputs, with run-time divisor load and elaboration-time cascading.
module clock_enable_generator #(
  parameter int                  CHANNELS = 4,
  parameter int                  WIDTH    = 16,
  parameter int                  DIV_INIT = 50,
  parameter logic [CHANNELS-1:0] CASCADE  = '0,
  localparam int                 CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CP,
  input  logic                nCR,
  input  logic                EN,
  input  logic                CLR,
  input  logic                LD,
  input  logic [CH_W-1:0]     LD_CH,
  input  logic [WIDTH-1:0]    LD_DIV,
  output logic                LD_ACK,
  output logic                LD_ERR,
  output logic [CHANNELS-1:0] TICK,
  output logic [CHANNELS-1:0] SQ
);
  logic [WIDTH-1:0]    div_q [CHANNELS];
  logic [WIDTH-1:0]    div_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] tick_q, tick_d, sq_q, sq_d, hit, evt, fire, zap;
  logic                ack_q, ack_d, err_q, err_d, ld_ok;

  always_comb begin
    ld_ok  = LD && (32'(LD_CH) < CHANNELS);
    ack_d  = ld_ok;
    err_d  = LD && !ld_ok;
    // channel 0 always counts clock cycles; cascaded channels count the upstream registered tick
    evt    = EN ? (~(CASCADE & ~CHANNELS'(1)) | (tick_q << 1)) : '0;
    hit    = '0;
    fire   = '0;
    zap    = '0;
    tick_d = '0;
    sq_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i]    = ld_ok && (LD_CH == CH_W'(i));
      zap[i]    = CLR || hit[i] || (div_q[i] == '0);
      fire[i]   = evt[i] && (cnt_q[i] == div_q[i] - WIDTH'(1));
      div_d[i]  = hit[i] ? LD_DIV : div_q[i];
      cnt_d[i]  = (zap[i] || fire[i]) ? '0 : cnt_q[i] + WIDTH'(evt[i]);
      tick_d[i] = !zap[i] && fire[i];
      sq_d[i]   = !zap[i] && (sq_q[i] ^ fire[i]);
    end
  end

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i] <= WIDTH'(DIV_INIT);
        cnt_q[i] <= '0;
      end
      tick_q <= '0;
      sq_q   <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  assign TICK   = tick_q;
  assign SQ     = sq_q;
  assign LD_ACK = ack_q;
  assign LD_ERR = err_q;
endmodule

// File: tb/tb_clock_enable_generator.sv
// tb_clock_enable_generator: directed scoreboard bench for the 4-channel cascaded build
// and a 3-channel build exercising the out-of-range load path.
module tb_clock_enable_generator;
  logic       CP = 1'b0;
  logic       nCR = 1'b0;
  logic       EN = 1'b0, CLR = 1'b0, LD = 1'b0;
  logic [1:0] LD_CH = '0;
  logic [7:0] LD_DIV = '0;
  logic       ack, err;
  logic [3:0] tick, sq;
  logic       en3 = 1'b0, ld3 = 1'b0;
  logic [1:0] ldch3 = '0;
  logic [7:0] lddiv3 = '0;
  logic       ack3, err3;
  logic [2:0] tick3, sq3;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    bit         sel;
    logic [9:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 CP = ~CP;

  clock_enable_generator #(.CHANNELS(4), .WIDTH(8), .DIV_INIT(5), .CASCADE(4'b0010)) dut (
    .CP(CP), .nCR(nCR), .EN(EN), .CLR(CLR), .LD(LD), .LD_CH(LD_CH), .LD_DIV(LD_DIV),
    .LD_ACK(ack), .LD_ERR(err), .TICK(tick), .SQ(sq)
  );

  clock_enable_generator #(.CHANNELS(3), .WIDTH(8), .DIV_INIT(5)) dut3 (
    .CP(CP), .nCR(nCR), .EN(en3), .CLR(1'b0), .LD(ld3), .LD_CH(ldch3), .LD_DIV(lddiv3),
    .LD_ACK(ack3), .LD_ERR(err3), .TICK(tick3), .SQ(sq3)
  );

  task push(input string tag, input bit sel, input logic [9:0] e);
    sb.push_back('{tag, sel, e});
  endtask

  task check_all();
    exp_t x;
    logic [9:0] got;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      got = x.sel ? {2'b00, tick3, sq3, ack3, err3} : {tick, sq, ack, err};
      total++;
      assert (got === x.exp) else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b", x.tag, got, x.exp);
      end
    end
  endtask

  task at(input int n);
    repeat (n) @(posedge CP);
    #1;
    check_all();
  endtask

  // observed word is {TICK, SQ, LD_ACK, LD_ERR}
  initial begin
    #12;
    push("rst", 0, 10'b0000_0000_00);
    push("rst3", 1, 10'b00_000_000_00);
    check_all();
    nCR = 1'b1; EN = 1'b1;
    en3 = 1'b1; ld3 = 1'b1; ldch3 = 2'd3; lddiv3 = 8'd2;
    push("err3", 1, 10'b00_000_000_01);
    at(1);
    ld3 = 1'b0;
    push("err3_off", 1, 10'b00_000_000_00);
    push("e2", 0, 10'b0000_0000_00);
    at(1);
    push("e4", 0, 10'b0000_0000_00);
    at(2);
    push("e5", 0, 10'b1101_1101_00);
    push("div3_kept", 1, 10'b00_111_111_00);
    at(1);
    push("e6", 0, 10'b0000_1101_00);
    at(1);
    push("e10", 0, 10'b1101_0000_00);
    at(4);
    push("e15", 0, 10'b1101_1101_00);
    at(5);
    LD = 1'b1; LD_CH = 2'd1; LD_DIV = 8'd3;
    push("ld1", 0, 10'b0000_1101_10);
    at(1);
    LD = 1'b0;
    push("e20", 0, 10'b1101_0000_00);
    at(4);
    push("e21", 0, 10'b0000_0000_00);
    at(1);
    push("casc_first", 0, 10'b0010_0010_00);
    at(10);
    push("casc_next", 0, 10'b0000_0010_00);
    at(1);
    push("casc_period", 0, 10'b0010_1101_00);
    at(14);
    LD = 1'b1; LD_CH = 2'd2; LD_DIV = 8'd1;
    push("ld2", 0, 10'b0000_1001_10);
    at(1);
    LD = 1'b0;
    push("div1_a", 0, 10'b0100_1101_00);
    at(1);
    push("div1_b", 0, 10'b0100_1001_00);
    at(1);
    push("div1_c", 0, 10'b1101_0100_00);
    at(1);
    LD = 1'b1; LD_CH = 2'd1; LD_DIV = 8'd0;
    push("ld_off", 0, 10'b0100_0000_10);
    at(1);
    LD = 1'b0;
    push("off_a", 0, 10'b0100_0000_00);
    at(10);
    push("off_b", 0, 10'b0100_1101_00);
    at(5);
    LD = 1'b1; LD_CH = 2'd1; LD_DIV = 8'd4;
    push("ld_on", 0, 10'b0100_1001_10);
    at(1);
    LD = 1'b0;
    push("on_a", 0, 10'b1101_1001_00);
    at(18);
    push("on_b", 0, 10'b0110_1111_00);
    at(1);
    push("pre_hold", 0, 10'b0100_1011_00);
    at(1);
    EN = 1'b0;
    push("hold_a", 0, 10'b0000_1011_00);
    at(1);
    push("hold_b", 0, 10'b0000_1011_00);
    at(6);
    EN = 1'b1;
    push("resume_a", 0, 10'b0100_1011_00);
    at(2);
    push("resume_b", 0, 10'b1101_0110_00);
    at(1);
    at(2);
    CLR = 1'b1; LD = 1'b1; LD_CH = 2'd0; LD_DIV = 8'd3;
    push("clr_ld", 0, 10'b0000_0000_10);
    at(1);
    CLR = 1'b0; LD = 1'b0;
    push("post_clr", 0, 10'b0100_0100_00);
    at(1);
    push("new_div0", 0, 10'b0101_0101_00);
    at(2);
    at(1);
    nCR = 1'b0;
    #2;
    push("async_rst", 0, 10'b0000_0000_00);
    check_all();
    #2;
    nCR = 1'b1;
    push("rst_e4", 0, 10'b0000_0000_00);
    at(4);
    push("rst_e5", 0, 10'b1101_1101_00);
    at(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
